// File: rtl/alu_uart_if_if.sv
// Bus bundle between the UART/ALU sequencer and its surroundings.
// master: the sequencer side (drives ALU operands and TX requests).
// slave:  the environment side (UART RX/TX and the combinational ALU).
interface alu_uart_if_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done;
  logic               i_tx_done;
  logic [NB_DATA-1:0] i_alu_result;
  logic [NB_DATA-1:0] o_data_a;
  logic [NB_DATA-1:0] o_data_b;
  logic [NB_OP-1:0]   o_op;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               o_busy;
  logic               o_rx_overrun;

  modport master (
    input  i_rx_data, i_rx_done, i_tx_done, i_alu_result,
    output o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_busy, o_rx_overrun
  );

  modport slave (
    output i_rx_data, i_rx_done, i_tx_done, i_alu_result,
    input  o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_busy, o_rx_overrun
  );
endinterface

// File: rtl/alu_uart_if.sv
// Sequencer between UART RX/TX and the combinational ALU.
// Collects operand A, operand B and the op code from three received bytes,
// presents them to the ALU, then hands the captured result to the UART TX.
// Optional feature: define ALU_IF_TIMEOUT_EN to abandon a partial
// A/B/op sequence after TIMEOUT_CYCLES idle cycles between bytes.
module alu_uart_if #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic          i_clk,
  input  logic          i_reset,
  alu_uart_if_if.master bus
);

  typedef enum logic [2:0] {
    S_WAIT_A,
    S_WAIT_B,
    S_WAIT_OP,
    S_EXEC,
    S_WAIT_TX
  } state_t;

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] data_a_q, data_a_d;
  logic [NB_DATA-1:0] data_b_q, data_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q, busy_d;
  logic               rx_overrun_q, rx_overrun_d;
  logic               timeout_hit;

`ifdef ALU_IF_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Idle-gap counter: only counts while a sequence is half received; an
  // arriving byte wins over expiry in the same cycle.
  always_comb begin
    cnt_d       = '0;
    timeout_hit = 1'b0;
    if ((state_q == S_WAIT_B || state_q == S_WAIT_OP) && !bus.i_rx_done) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        timeout_hit = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and output computation; everything holds unless a transition
  // updates it, tx_start is a single-cycle pulse.
  always_comb begin
    state_d      = state_q;
    data_a_d     = data_a_q;
    data_b_d     = data_b_q;
    op_d         = op_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    rx_overrun_d = rx_overrun_q;
    case (state_q)
      S_WAIT_A: begin
        if (bus.i_rx_done) begin
          data_a_d = bus.i_rx_data;
          state_d  = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (bus.i_rx_done) begin
          data_b_d = bus.i_rx_data;
          state_d  = S_WAIT_OP;
        end else if (timeout_hit) begin
          state_d = S_WAIT_A;
        end
      end
      S_WAIT_OP: begin
        if (bus.i_rx_done) begin
          op_d    = bus.i_rx_data[NB_OP-1:0];
          state_d = S_EXEC;
        end else if (timeout_hit) begin
          state_d = S_WAIT_A;
        end
      end
      S_EXEC: begin
        // ALU has had a full cycle to settle on the new operands/op.
        tx_data_d  = bus.i_alu_result;
        tx_start_d = 1'b1;
        state_d    = S_WAIT_TX;
        if (bus.i_rx_done) begin
          rx_overrun_d = 1'b1;
        end
      end
      S_WAIT_TX: begin
        if (bus.i_tx_done) begin
          state_d = S_WAIT_A;
        end
        if (bus.i_rx_done) begin
          rx_overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = S_WAIT_A;
      end
    endcase
    busy_d = (state_d == S_EXEC) || (state_d == S_WAIT_TX);
  end

  // State and output registers; reset abandons any pending transmission.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_WAIT_A;
      data_a_q     <= '0;
      data_b_q     <= '0;
      op_q         <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_a_q     <= data_a_d;
      data_b_q     <= data_b_d;
      op_q         <= op_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      busy_q       <= busy_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  assign bus.o_data_a     = data_a_q;
  assign bus.o_data_b     = data_b_q;
  assign bus.o_op         = op_q;
  assign bus.o_tx_data    = tx_data_q;
  assign bus.o_tx_start   = tx_start_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_alu_uart_if.sv
// Testbench for alu_uart_if: directed and randomized byte sequences checked
// against a transaction-level reference (expected operands, ALU result,
// pulse timing, sticky overrun). Timeout checks run when ALU_IF_TIMEOUT_EN
// is defined (TIMEOUT_CYCLES=16).
module tb_alu_uart_if;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  bit   exp_ovr = 1'b0;

  always #5 clk = ~clk;

  alu_uart_if_if #(.NB_DATA(8), .NB_OP(6)) bus ();

  alu_uart_if #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(16)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus.master)
  );

  // Behavioural ALU model (MIPS-style function codes).
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return 8'($signed(a) >>> b[2:0]);
      6'h02:   return a >> b[2:0];
      default: return 8'h00;
    endcase
  endfunction

  assign bus.i_alu_result = alu_ref(bus.o_data_a, bus.o_data_b, bus.o_op);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    step();
    bus.i_rx_done = 1'b0;
  endtask

  // Called right after the op byte was accepted (cycle N+1).
  // inj: 0 none, 1 stray byte in EXEC, 2 stray byte in WAIT_TX (needs delay>0)
  task automatic finish_txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] opb, input int delay, input int inj);
    logic [5:0] eop;
    logic [7:0] eres;
    eop  = opb[5:0];
    eres = alu_ref(a, b, eop);
    check({tag, ".a"}, bus.o_data_a, a);
    check({tag, ".b"}, bus.o_data_b, b);
    check({tag, ".op"}, bus.o_op, eop);
    check({tag, ".busy_exec"}, bus.o_busy, 1);
    check({tag, ".start_n1"}, bus.o_tx_start, 0);
    if (inj == 1) begin
      bus.i_rx_data = 8'h77;
      bus.i_rx_done = 1'b1;
      exp_ovr = 1'b1;
    end
    step();
    bus.i_rx_done = 1'b0;
    check({tag, ".start_n2"}, bus.o_tx_start, 1);
    check({tag, ".tx_data"}, bus.o_tx_data, eres);
    if (delay == 0) begin
      bus.i_tx_done = 1'b1;
      step();
      bus.i_tx_done = 1'b0;
    end else begin
      if (inj == 2) begin
        bus.i_rx_data = 8'h77;
        bus.i_rx_done = 1'b1;
        exp_ovr = 1'b1;
      end
      step();
      bus.i_rx_done = 1'b0;
      check({tag, ".start_n3"}, bus.o_tx_start, 0);
      check({tag, ".busy_tx"}, bus.o_busy, 1);
      repeat (delay - 1) step();
      check({tag, ".tx_hold"}, bus.o_tx_data, eres);
      bus.i_tx_done = 1'b1;
      step();
      bus.i_tx_done = 1'b0;
    end
    check({tag, ".busy_done"}, bus.o_busy, 0);
    check({tag, ".ovr"}, bus.o_rx_overrun, exp_ovr);
    // Operands are not disturbed by a dropped byte.
    check({tag, ".a_keep"}, bus.o_data_a, a);
  endtask

  task automatic txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] opb, input int delay, input int inj, input int gap);
    send(a);
    repeat (gap) step();
    send(b);
    repeat (gap) step();
    send(opb);
    finish_txn(tag, a, b, opb, delay, inj);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [7:0] ra, rb, rop;
    bus.i_rx_data = '0;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;

    // Reset held two cycles.
    rst = 1'b1;
    step();
    step();
    check("rst.a", bus.o_data_a, 0);
    check("rst.b", bus.o_data_b, 0);
    check("rst.op", bus.o_op, 0);
    check("rst.tx_data", bus.o_tx_data, 0);
    check("rst.start", bus.o_tx_start, 0);
    check("rst.busy", bus.o_busy, 0);
    check("rst.ovr", bus.o_rx_overrun, 0);
    rst = 1'b0;

    // Directed transactions.
    txn("add", 8'h05, 8'h03, 8'h20, 3, 0, 0);
    txn("sub", 8'h03, 8'h05, 8'h22, 2, 0, 1);
    txn("ovr", 8'hA5, 8'h0F, 8'h24, 4, 2, 0);
    check("ovr.sticky", bus.o_rx_overrun, 1);
    txn("after_ovr", 8'h40, 8'h02, 8'h02, 0, 0, 0);
    txn("op_trunc", 8'h81, 8'h01, 8'hE3, 1, 0, 0);

    // Partial sequence keeps older B/op; stray tx_done outside WAIT_TX ignored.
    send(8'h5A);
    check("hold.a", bus.o_data_a, 8'h5A);
    check("hold.b", bus.o_data_b, 8'h01);
    check("hold.op", bus.o_op, 6'h23);
    bus.i_tx_done = 1'b1;
    step();
    bus.i_tx_done = 1'b0;
    check("stray_txdone.busy", bus.o_busy, 0);
    send(8'h0F);
    send(8'h26);
    finish_txn("hold_rest", 8'h5A, 8'h0F, 8'h26, 1, 0);

    // Reset mid-sequence: next byte is operand A again; overrun cleared.
    send(8'h11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_ovr = 1'b0;
    check("midrst.a", bus.o_data_a, 0);
    check("midrst.ovr", bus.o_rx_overrun, 0);
    txn("post_rst", 8'h22, 8'h33, 8'h24, 2, 0, 0);

    // Reset in EXEC: the pending result is never transmitted.
    send(8'h07);
    send(8'h08);
    send(8'h20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    seen = 0;
    repeat (5) begin
      if (bus.o_tx_start === 1'b1) seen++;
      step();
    end
    check("exec_rst.no_start", seen, 0);
    check("exec_rst.busy", bus.o_busy, 0);
    txn("after_exec_rst", 8'h10, 8'h20, 8'h25, 1, 0, 0);

`ifdef ALU_IF_TIMEOUT_EN
    // 16 idle cycles after A: sequence abandoned, next byte is A.
    send(8'h01);
    repeat (16) step();
    send(8'h09);
    check("tmo.a", bus.o_data_a, 8'h09);
    check("tmo.b_keep", bus.o_data_b, 8'h20);
    send(8'h02);
    send(8'h20);
    finish_txn("tmo_rest", 8'h09, 8'h02, 8'h20, 1, 0);
    // Byte arriving at the boundary is still accepted as B.
    send(8'h01);
    repeat (15) step();
    send(8'h0C);
    check("tmo_edge.a", bus.o_data_a, 8'h01);
    check("tmo_edge.b", bus.o_data_b, 8'h0C);
    send(8'h22);
    finish_txn("tmo_edge_rest", 8'h01, 8'h0C, 8'h22, 1, 0);
`endif

    // Randomized transactions against the reference.
    for (int i = 0; i < 24; i++) begin
      int d, inj;
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      case ($urandom_range(0, 8))
        0: rop = 8'h20;
        1: rop = 8'h22;
        2: rop = 8'h24;
        3: rop = 8'h25;
        4: rop = 8'h26;
        5: rop = 8'h27;
        6: rop = 8'h03;
        7: rop = 8'h02;
        default: rop = 8'($urandom);
      endcase
      d   = int'($urandom_range(0, 5));
      inj = int'($urandom_range(0, 5));
      if (inj > 2 || (inj == 2 && d == 0)) inj = 0;
      txn($sformatf("rnd%0d", i), ra, rb, rop, d, inj, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
